// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit instruction memory
// writes, then releases the CPU and forwards its PC as the read index.
// Optional build macro IMEM_BOOT_CHECKSUM_EN adds a trailing XOR checksum word.
module imem_boot_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       cpu_addr,
  output logic [ADDR_W-1:0] imem_raddr,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

`ifdef IMEM_BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN} state_t;
`endif

  state_t            state, state_n;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_cnt;
  logic [1:0]        byte_cnt;
  logic [31:0]       sh;
  logic              err_q;
  logic              done_q;
  logic [ADDR_W-1:0] raddr_q;

  logic              start_ok;
  logic              xfer;
  logic              enter_run;
  logic              last_word;
  logic [31:0]       sh_nxt;
  logic [ADDR_W:0]   len_clamped;
  logic              len_over;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0]       csum;
  logic              csum_bad;
`endif

  // Only the word-index bits of the PC select an entry; the rest wrap away.
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};

  always_comb begin
    start_ok    = start && ((state == S_IDLE) || (state == S_RUN));
    in_ready    = (state == S_LOAD);
`ifdef IMEM_BOOT_CHECKSUM_EN
    in_ready    = in_ready || (state == S_CHECK);
    csum_bad    = 1'b0;
`endif
    xfer        = in_valid && in_ready;
    sh_nxt      = {in_byte, sh[31:8]};
    len_over    = (len > DEPTH_L);
    len_clamped = len_over ? DEPTH_L : len;
    last_word   = ((word_cnt + 1'b1) == len_q);
    state_n     = state;

    case (state)
      S_IDLE, S_RUN: begin
        if (start_ok) begin
          if (len == '0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            state_n = S_CHECK;
`else
            state_n = S_RUN;
`endif
          end else begin
            state_n = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (xfer && (byte_cnt == 2'd3)) state_n = S_WRITE;
      end
      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_RUN;
`endif
        end else begin
          state_n = S_LOAD;
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      S_CHECK: begin
        if (xfer && (byte_cnt == 2'd3)) begin
          csum_bad = (sh_nxt != csum);
          state_n  = csum_bad ? S_IDLE : S_RUN;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // A restart from RUN straight back into RUN still counts as a fresh entry.
    enter_run = (state_n == S_RUN) && ((state != S_RUN) || start_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      raddr_q  <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      state   <= state_n;
      done_q  <= enter_run;
      raddr_q <= ((state == S_RUN) && !start_ok) ? cpu_addr[ADDR_W+1:2] : '0;

      if (start_ok) begin
        len_q    <= len_clamped;
        word_cnt <= '0;
        byte_cnt <= '0;
        sh       <= '0;
        err_q    <= len_over;
`ifdef IMEM_BOOT_CHECKSUM_EN
        csum     <= '0;
`endif
      end else begin
        if (xfer) begin
          sh       <= sh_nxt;
          byte_cnt <= byte_cnt + 2'd1;
        end
        if (state == S_WRITE) begin
          word_cnt <= word_cnt + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
          csum     <= csum ^ sh;
`endif
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        if (csum_bad) err_q <= 1'b1;
`endif
      end
    end
  end

  always_comb begin
    imem_we    = (state == S_WRITE);
    imem_waddr = imem_we ? word_cnt[ADDR_W-1:0] : '0;
    imem_wdata = imem_we ? sh : '0;
    busy       = (state == S_LOAD) || (state == S_WRITE);
    cpu_run    = (state == S_RUN);
    done       = done_q;
    err        = err_q;
    imem_raddr = raddr_q;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: write scoreboard plus fetch-index table.
module tb_imem_boot_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [ADDR_W:0]   len;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready, imem_we, cpu_run, busy, done, err;
  logic [ADDR_W-1:0] imem_waddr, imem_raddr;
  logic [31:0]       imem_wdata, cpu_addr;

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_addr(cpu_addr), .imem_raddr(imem_raddr), .cpu_run(cpu_run),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  typedef struct { logic [31:0] addr; logic [ADDR_W-1:0] exp; } fv_t;
  fv_t fv[6];

  logic [31:0] prog [0:69];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got waddr %0d data 0x%0h expected no write",
                 imem_waddr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(imem_waddr), 64'(e.a));
        check("write_data", 64'(imem_wdata), 64'(e.d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1;
    len   = l[ADDR_W:0];
    tick();
    start = 1'b0;
  endtask

  function automatic int nwords(input int l);
    return (l > DEPTH) ? DEPTH : l;
  endfunction

  function automatic logic [31:0] csum_of(input int n);
    logic [31:0] c = '0;
    for (int i = 0; i < n; i++) c = c ^ prog[i];
    return c;
  endfunction

  task automatic push_prog(input int l);
    for (int i = 0; i < nwords(l); i++) begin
      wr_t e;
      e.a = i[ADDR_W-1:0];
      e.d = prog[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got in_ready %b expected 1 within 50 cycles", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic send_tail(input int l);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send_word(csum_of(nwords(l)));
`else
    if (l < 0) send_word('0);
`endif
  endtask

  task automatic wait_run();
    int k;
    k = 0;
    while (cpu_run !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check("run_reached", 64'(cpu_run), 64'd1);
    check("done_first_run_cycle", 64'(done), 64'd1);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("run_stays", 64'(cpu_run), 64'd1);
  endtask

  task automatic load(input int l);
    push_prog(l);
    pulse_start(l);
    for (int i = 0; i < nwords(l); i++) send_word(prog[i]);
    send_tail(l);
    wait_run();
  endtask

  logic [ADDR_W-1:0] prev;

  initial begin
    fv[0] = '{32'h0000_0004, 6'd1};
    fv[1] = '{32'h0000_0100, 6'd0};
    fv[2] = '{32'h0000_00FC, 6'd63};
    fv[3] = '{32'h0000_0008, 6'd2};
    fv[4] = '{32'hFFFF_FFF0, 6'd60};
    fv[5] = '{32'h0000_0087, 6'd33};

    reset = 1'b1; start = 1'b0; len = '0; in_byte = '0; in_valid = 1'b0; cpu_addr = '0;
    repeat (3) tick();
    check("reset_outputs",
          64'({in_ready, imem_we, imem_waddr, imem_wdata, imem_raddr, cpu_run, busy, done, err}),
          64'd0);
    reset = 1'b0;
    tick();
    check("idle_no_ready", 64'(in_ready), 64'd0);

    // Basic two-word load: bytes 13 00 00 00 93 00 10 00
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    push_prog(2);
    pulse_start(2);
    check("load_busy", 64'(busy), 64'd1);
    check("load_ready", 64'(in_ready), 64'd1);
    check("load_err", 64'(err), 64'd0);
    send_word(prog[0]);
    send_word(prog[1]);
    send_tail(2);
    wait_run();
    check("basic_writes", 64'(wr_cnt), 64'd2);

    // Fetch index table, one cycle of latency
    prev = '0;
    for (int i = 0; i < 6; i++) begin
      cpu_addr = fv[i].addr;
      #1;
      check("fetch_latency", 64'(imem_raddr), 64'(prev));
      @(posedge clk);
      #1;
      check("fetch_raddr", 64'(imem_raddr), 64'(fv[i].exp));
      prev = fv[i].exp;
    end

    // Restart from RUN with backpressure between bytes 2 and 3
    prog[0] = 32'hA1B2_C3D4;
    push_prog(1);
    pulse_start(1);
    check("restart_cpu_run", 64'(cpu_run), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_raddr", 64'(imem_raddr), 64'd0);
    send_byte(8'hD4);
    send_byte(8'hC3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", 64'(in_ready), 64'd1);
      check("stall_no_write", 64'(wr_cnt), 64'd2);
    end
    send_byte(8'hB2);
    send_byte(8'hA1);
    send_tail(1);
    wait_run();
    check("stall_writes", 64'(wr_cnt), 64'd3);

    // start during LOAD must be ignored
    prog[0] = 32'h0BAD_F00D;
    prog[1] = 32'h1234_5678;
    push_prog(2);
    pulse_start(2);
    send_byte(8'h0D);
    pulse_start(5);
    check("ignored_start_busy", 64'(busy), 64'd1);
    send_byte(8'hF0);
    send_byte(8'hAD);
    send_byte(8'h0B);
    send_word(prog[1]);
    send_tail(2);
    wait_run();
    check("ignored_start_writes", 64'(wr_cnt), 64'd5);

    // Clamp: len 70 writes 64 words and flags err
    for (int i = 0; i < DEPTH; i++) prog[i] = 32'h9E37_79B9 * (i + 1);
    push_prog(70);
    pulse_start(70);
    check("clamp_err_set", 64'(err), 64'd1);
    for (int i = 0; i < DEPTH; i++) send_word(prog[i]);
    send_tail(70);
    wait_run();
    check("clamp_err_sticky", 64'(err), 64'd1);
    check("clamp_writes", 64'(wr_cnt), 64'd69);

    prog[0] = 32'hCAFE_BABE;
    push_prog(1);
    pulse_start(1);
    check("clamp_err_cleared", 64'(err), 64'd0);
    send_word(prog[0]);
    send_tail(1);
    wait_run();

    // len == 0: nothing written
`ifdef IMEM_BOOT_CHECKSUM_EN
    pulse_start(0);
    send_word(32'h0);
    wait_run();
`else
    pulse_start(0);
    check("len0_run", 64'(cpu_run), 64'd1);
    check("len0_done", 64'(done), 64'd1);
    tick();
    check("len0_done_end", 64'(done), 64'd0);
`endif
    check("len0_no_write", 64'(wr_cnt), 64'd70);

    // Reset mid-load (with start asserted too): reset wins, partial bytes dropped
    pulse_start(1);
    send_byte(8'hAA);
    send_byte(8'h55);
    start = 1'b1;
    len   = 7'd3;
    reset = 1'b1;
    tick();
    start = 1'b0;
    check("midload_reset_outputs",
          64'({in_ready, imem_we, imem_waddr, imem_wdata, imem_raddr, cpu_run, busy, done, err}),
          64'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("after_reset_idle", 64'({in_ready, cpu_run, busy}), 64'd0);
    check("after_reset_no_write", 64'(wr_cnt), 64'd70);

    prog[0] = 32'h8765_4321;
    load(1);
    check("reload_writes", 64'(wr_cnt), 64'd71);

`ifdef IMEM_BOOT_CHECKSUM_EN
    prog[0] = 32'h1111_1111;
    prog[1] = 32'h2222_2222;
    push_prog(2);
    pulse_start(2);
    send_word(prog[0]);
    send_word(prog[1]);
    send_word(32'h3333_3333);
    wait_run();
    check("csum_ok_err", 64'(err), 64'd0);

    push_prog(2);
    pulse_start(2);
    send_word(prog[0]);
    send_word(prog[1]);
    send_word(32'h3333_3334);
    check("csum_bad_err", 64'(err), 64'd1);
    check("csum_bad_idle", 64'({cpu_run, busy, done, in_ready}), 64'd0);
    repeat (2) tick();
    check("csum_bad_stays_idle", 64'({cpu_run, done}), 64'd0);
`endif

    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
